// File: rtl/iob_eth_rx_slot_ctrl.sv
// iob_eth_rx_slot_ctrl: places RX frames into a ring of NSLOTS buffer slots and queues per-frame descriptors.
// Build option ETH_RX_CRC_DROP_EN: frames with a bad CRC are discarded instead of committed.
`default_nettype none

module iob_eth_rx_slot_ctrl #(
  parameter int unsigned  NSLOTS      = 4,
  parameter logic [31:0]  CRC_RESIDUE = 32'hC704DD7B,
  localparam int unsigned SLOT_W      = $clog2(NSLOTS)
) (
  input  logic               RX_CLK,
  input  logic               rst,
  input  logic               rx_wr,
  input  logic [10:0]        rx_addr,
  input  logic               data_rcvd,
  input  logic [31:0]        crc_value,
  output logic               rcv_ack,
  output logic               buf_wr,
  output logic [SLOT_W+10:0] buf_addr,
  output logic               rd_valid,
  output logic [SLOT_W-1:0]  rd_slot,
  output logic [10:0]        rd_len,
  output logic               rd_crc_ok,
  input  logic               rd_pop,
  output logic [SLOT_W:0]    occupancy,
  output logic [15:0]        drop_cnt,
  output logic [15:0]        crc_err_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, ACK = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               rcv_ack_q, rcv_ack_d;
  logic               drop_q, drop_d;
  logic               buf_wr_q, buf_wr_d;
  logic [SLOT_W+10:0] buf_addr_q;
  logic [SLOT_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [SLOT_W:0]    occ_q;
  logic [10:0]        desc_len_q [NSLOTS];
  logic               desc_ok_q  [NSLOTS];
  logic               rd_valid_q;
  logic [SLOT_W-1:0]  rd_slot_q;
  logic [10:0]        rd_len_q;
  logic               rd_crc_ok_q;
  logic [SLOT_W:0]    occupancy_q;
  logic [15:0]        drop_cnt_q, crc_err_cnt_q;
  logic               commit, drop_evt, crc_bad, pop_ok, ring_full, crc_ok, keep;

  assign crc_ok    = (crc_value == CRC_RESIDUE);
  assign ring_full = (occ_q == (SLOT_W+1)'(NSLOTS));
  // Pop needs the host-visible valid and a non-empty ring, so stale rd_valid cannot underflow.
  assign pop_ok    = rd_pop & rd_valid_q & (occ_q != '0);

`ifdef ETH_RX_CRC_DROP_EN
  assign keep = crc_ok;
`else
  assign keep = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    rcv_ack_d = rcv_ack_q;
    drop_d    = drop_q;
    buf_wr_d  = 1'b0;
    commit    = 1'b0;
    drop_evt  = 1'b0;
    crc_bad   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_rcvd) begin
          state_d   = ACK;
          rcv_ack_d = 1'b1;
        end else if (rx_wr && (rx_addr == 11'd0)) begin
          state_d  = RECV;
          drop_d   = ring_full;
          buf_wr_d = ~ring_full;
        end
      end
      RECV: begin
        buf_wr_d = rx_wr & ~drop_q;
        if (data_rcvd) begin
          state_d   = ACK;
          rcv_ack_d = 1'b1;
          crc_bad   = ~crc_ok;
          drop_evt  = drop_q;
          commit    = ~drop_q & keep;
        end
      end
      ACK: begin
        if (!data_rcvd) begin
          state_d   = IDLE;
          rcv_ack_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rcv_ack_q     <= 1'b0;
      drop_q        <= 1'b0;
      buf_wr_q      <= 1'b0;
      buf_addr_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      rd_valid_q    <= 1'b0;
      rd_slot_q     <= '0;
      rd_len_q      <= '0;
      rd_crc_ok_q   <= 1'b0;
      occupancy_q   <= '0;
      drop_cnt_q    <= '0;
      crc_err_cnt_q <= '0;
      for (int unsigned i = 0; i < NSLOTS; i++) begin
        desc_len_q[i] <= '0;
        desc_ok_q[i]  <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      rcv_ack_q  <= rcv_ack_d;
      drop_q     <= drop_d;
      buf_wr_q   <= buf_wr_d;
      buf_addr_q <= {wr_ptr_q, rx_addr};

      if (commit) begin
        desc_len_q[wr_ptr_q] <= rx_addr;
        desc_ok_q[wr_ptr_q]  <= crc_ok;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;

      if (commit && !pop_ok)      occ_q <= occ_q + 1'b1;
      else if (!commit && pop_ok) occ_q <= occ_q - 1'b1;

      if (drop_evt && (drop_cnt_q != 16'hFFFF))   drop_cnt_q    <= drop_cnt_q + 16'd1;
      if (crc_bad && (crc_err_cnt_q != 16'hFFFF)) crc_err_cnt_q <= crc_err_cnt_q + 16'd1;

      // Host view trails the ring state by one edge.
      rd_valid_q  <= (occ_q != '0);
      rd_slot_q   <= rd_ptr_q;
      rd_len_q    <= desc_len_q[rd_ptr_q];
      rd_crc_ok_q <= desc_ok_q[rd_ptr_q];
      occupancy_q <= occ_q;
    end
  end

  assign rcv_ack     = rcv_ack_q;
  assign buf_wr      = buf_wr_q;
  assign buf_addr    = buf_addr_q;
  assign rd_valid    = rd_valid_q;
  assign rd_slot     = rd_slot_q;
  assign rd_len      = rd_len_q;
  assign rd_crc_ok   = rd_crc_ok_q;
  assign occupancy   = occupancy_q;
  assign drop_cnt    = drop_cnt_q;
  assign crc_err_cnt = crc_err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_iob_eth_rx_slot_ctrl.sv
// tb_iob_eth_rx_slot_ctrl: directed and randomized frames against a queue-based ring model.
`default_nettype none

module tb_iob_eth_rx_slot_ctrl;
  localparam int          NSLOTS = 4;
  localparam logic [31:0] RES    = 32'hC704DD7B;
`ifdef ETH_RX_CRC_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        RX_CLK = 1'b0;
  logic        rst = 1'b1;
  logic        rx_wr = 1'b0;
  logic [10:0] rx_addr = '0;
  logic        data_rcvd = 1'b0;
  logic [31:0] crc_value = '0;
  logic        rd_pop = 1'b0;
  logic        rcv_ack, buf_wr, rd_valid, rd_crc_ok;
  logic [12:0] buf_addr;
  logic [1:0]  rd_slot;
  logic [10:0] rd_len;
  logic [2:0]  occupancy;
  logic [15:0] drop_cnt, crc_err_cnt;

  iob_eth_rx_slot_ctrl #(.NSLOTS(NSLOTS), .CRC_RESIDUE(RES)) dut (
    .RX_CLK(RX_CLK), .rst(rst), .rx_wr(rx_wr), .rx_addr(rx_addr),
    .data_rcvd(data_rcvd), .crc_value(crc_value), .rcv_ack(rcv_ack),
    .buf_wr(buf_wr), .buf_addr(buf_addr), .rd_valid(rd_valid), .rd_slot(rd_slot),
    .rd_len(rd_len), .rd_crc_ok(rd_crc_ok), .rd_pop(rd_pop), .occupancy(occupancy),
    .drop_cnt(drop_cnt), .crc_err_cnt(crc_err_cnt)
  );

  always #5 RX_CLK = ~RX_CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: committed frames in arrival order plus slot counters.
  int q_len[$];
  bit q_ok[$];
  int m_wr = 0, m_rd = 0, m_drop = 0, m_crcerr = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge RX_CLK);
    #1;
  endtask

  task automatic model_pop();
    if (q_len.size() != 0) begin
      void'(q_len.pop_front());
      void'(q_ok.pop_front());
      m_rd = (m_rd + 1) % NSLOTS;
    end
  endtask

  task automatic model_reset();
    q_len.delete();
    q_ok.delete();
    m_wr = 0; m_rd = 0; m_drop = 0; m_crcerr = 0;
  endtask

  task automatic check_state();
    check_eq("occupancy", 32'(occupancy), 32'(q_len.size()));
    check_eq("rd_valid", 32'(rd_valid), 32'(q_len.size() != 0));
    check_eq("rd_slot", 32'(rd_slot), 32'(m_rd));
    check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check_eq("crc_err_cnt", 32'(crc_err_cnt), 32'(m_crcerr));
    if (q_len.size() != 0) begin
      check_eq("rd_len", 32'(rd_len), 32'(q_len[0]));
      check_eq("rd_crc_ok", 32'(rd_crc_ok), 32'(q_ok[0]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rcv_ack"}, 32'(rcv_ack), 32'd0);
    check_eq({tag, "_buf_wr"}, 32'(buf_wr), 32'd0);
    check_eq({tag, "_buf_addr"}, 32'(buf_addr), 32'd0);
    check_eq({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check_eq({tag, "_rd_slot"}, 32'(rd_slot), 32'd0);
    check_eq({tag, "_rd_len"}, 32'(rd_len), 32'd0);
    check_eq({tag, "_rd_crc_ok"}, 32'(rd_crc_ok), 32'd0);
    check_eq({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    check_eq({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
    check_eq({tag, "_crc_err_cnt"}, 32'(crc_err_cnt), 32'd0);
  endtask

  task automatic send_frame(input int len, input bit good, input bit pop_end);
    bit full;
    int slot;
    full = (q_len.size() == NSLOTS);
    slot = m_wr;
    crc_value = good ? RES : (RES ^ 32'($urandom_range(255, 1)));
    for (int a = 0; a < len; a++) begin
      rx_wr = 1'b1;
      rx_addr = 11'(a);
      tick();
      check_eq("buf_wr", 32'(buf_wr), 32'(!full));
      check_eq("buf_addr", 32'(buf_addr), 32'(slot * 2048 + a));
    end
    rx_wr = 1'b0;
    rx_addr = 11'(len);
    data_rcvd = 1'b1;
    rd_pop = pop_end;
    tick();
    rd_pop = 1'b0;
    check_eq("rcv_ack_rise", 32'(rcv_ack), 32'd1);
    if (pop_end) model_pop();
    if (!good) m_crcerr++;
    if (full) m_drop++;
    else if (good || !DROP_EN) begin
      q_len.push_back(len);
      q_ok.push_back(good);
      m_wr = (m_wr + 1) % NSLOTS;
    end
    tick();
    check_state();
    check_eq("rcv_ack_hold", 32'(rcv_ack), 32'd1);
    repeat ($urandom_range(2)) begin
      tick();
      check_eq("rcv_ack_hold", 32'(rcv_ack), 32'd1);
    end
    data_rcvd = 1'b0;
    tick();
    check_eq("rcv_ack_fall", 32'(rcv_ack), 32'd0);
    tick();
  endtask

  task automatic pop_one();
    rd_pop = 1'b1;
    tick();
    rd_pop = 1'b0;
    model_pop();
    tick();
    check_state();
  endtask

  initial begin
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) tick();
    check_all_zero("post_reset");

    pop_one();                       // pop on empty ring is ignored
    send_frame(64, 1'b1, 1'b0);      // first good frame to slot 0
    send_frame(17, 1'b1, 1'b0);
    send_frame(5, 1'b1, 1'b0);       // occupancy 3, wr 3, rd 0
    send_frame(30, 1'b1, 1'b1);      // commit into slot 3 with simultaneous pop
    send_frame(12, 1'b1, 1'b0);      // ring full
    send_frame(20, 1'b1, 1'b0);      // dropped
    send_frame(9, 1'b0, 1'b0);       // bad CRC while full: dropped and counted
    repeat (4) pop_one();
    send_frame(40, 1'b0, 1'b0);      // bad CRC on empty ring
    send_frame(8, 1'b1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      send_frame($urandom_range(100, 1), ($urandom % 4) != 0, ($urandom % 3) == 0);
      if (($urandom % 2) == 0) pop_one();
    end

    // Asynchronous reset in the middle of a frame
    crc_value = RES;
    for (int a = 0; a < 20; a++) begin
      rx_wr = 1'b1;
      rx_addr = 11'(a);
      tick();
    end
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    rx_wr = 1'b0;
    rx_addr = '0;
    #2;
    rst = 1'b0;
    repeat (2) tick();
    send_frame(10, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iob_eth_rx_slot_ctrl.md
# iob_eth_rx_slot_ctrl

Receive-buffer slot controller for the Ethernet RX path, running entirely in the RX_CLK domain. It sits between the frame receiver and the RX frame memory. It maps each incoming frame into one of NSLOTS fixed-size buffer slots arranged as a ring, and validates the frame CRC on completion. It commits a descriptor (length, CRC status) for the host side, acknowledges the receiver, and drops frames when the ring is full.

## Interface
- NSLOTS, 4: number of frame slots; power of two, 2..16. SLOT_W = $clog2(NSLOTS).
- CRC_RESIDUE, 32'hC704DD7B: crc_value of a frame whose FCS is correct.

Ports:
- Reset is `rst`, asynchronous, active-high; the clock is `RX_CLK`.
- RX_CLK  in  1  receive clock.
- rst  in  1  async active-high reset.
- rx_wr  in  1  receiver byte write strobe.
- rx_addr  in  11  receiver byte address within frame.
- data_rcvd  in  1  receiver frame-complete level; held until acknowledged.
- crc_value  in  32  receiver running CRC.
- rcv_ack  out  1  frame acknowledge to receiver (level).
- buf_wr  out  1  frame memory write enable.
- buf_addr  out  SLOT_W+11  {slot, byte address} into frame memory.
- rd_valid  out  1  at least one committed frame pending.
- rd_slot  out  SLOT_W  slot index of oldest committed frame.
- rd_len  out  11  byte count of that frame (incl. FCS).
- rd_crc_ok  out  1  CRC status of that frame.
- rd_pop  in  1  host releases oldest frame (single-cycle pulse).
- occupancy  out  SLOT_W+1  committed slots, 0..NSLOTS.
- drop_cnt  out  16  frames dropped for ring full, saturating.
- crc_err_cnt  out  16  frames with bad CRC, saturating.

## Operation
- Ring state: wr_ptr and rd_ptr, each SLOT_W bits and wrapping modulo NSLOTS; occupancy counter; per-slot descriptor {len[10:0], crc_ok}.
- The FSM has three states: IDLE, RECV and ACK.
  - IDLE: when rx_wr=1 and rx_addr=0, go to RECV and latch drop = (occupancy==NSLOTS). If data_rcvd=1 arrives in IDLE, go straight to ACK without committing anything.
  - RECV: forward writes. On data_rcvd=1, perform the commit decision, set rcv_ack=1 and go to ACK.
  - ACK: hold rcv_ack=1 until data_rcvd=0, then clear rcv_ack and go to IDLE.
- Write forwarding: buf_wr = rx_wr & ~drop, qualified by state RECV or by the IDLE start condition. buf_addr = {wr_ptr, rx_addr}.
- Commit decision:
  - crc_ok = (crc_value == CRC_RESIDUE). If crc_ok=0, crc_err_cnt increments.
  - If drop=1: no commit, and drop_cnt increments.
  - Otherwise: write descriptor[wr_ptr] = {rx_addr, crc_ok}, increment wr_ptr and occupancy. The exception is the CRC-drop case described under Configuration.
- Host side:
  - rd_valid = (occupancy != 0). rd_slot = rd_ptr. rd_len and rd_crc_ok come from descriptor[rd_ptr].
  - rd_pop with rd_valid=1 increments rd_ptr and decrements occupancy. rd_pop with rd_valid=0 is ignored.
- Simultaneous commit and pop: both pointers advance and occupancy is unchanged.
- Counters stick at 16'hFFFF.

## Timing
- Reset values: rcv_ack=0, buf_wr=0, buf_addr=0, rd_valid=0, rd_slot=0, rd_len=0, rd_crc_ok=0, occupancy=0, drop_cnt=0, crc_err_cnt=0. Pointers are 0 and the state is IDLE.
- buf_wr and buf_addr are registered, with 1-cycle latency from rx_wr/rx_addr.
- Commit and rcv_ack rise occur on the same edge, the first edge where data_rcvd=1 is sampled in RECV.
- rd_valid, rd_len and occupancy update on the following edge, so a descriptor is visible 1 cycle after commit.
- rcv_ack falls on the first edge after data_rcvd is sampled 0.
- The full check is made once per frame at its start. A pop mid-frame does not un-drop that frame.
- rst mid-frame: all state returns to reset values immediately (async). In-flight and committed frames are lost. The receiver is assumed to be reset by the same rst.

## Configuration
- ETH_RX_CRC_DROP_EN defined: a frame with a bad CRC is not committed. wr_ptr is not advanced, so the slot is reused by the next frame. crc_err_cnt still increments. rd_crc_ok is always 1.
- Undefined: a bad-CRC frame is committed with crc_ok=0, and crc_err_cnt increments.

## Test plan
- Single good frame, NSLOTS=4, 64 writes, rx_addr ends at 64, crc_value=CRC_RESIDUE: buf_addr upper bits=0. One cycle after rcv_ack rises, rd_valid=1, rd_slot=0, rd_len=64, rd_crc_ok=1, occupancy=1. rcv_ack clears 1 cycle after data_rcvd falls.
- Five good frames with no pops: frames 1–4 go to slots 0..3 and occupancy=4. Frame 5 produces buf_wr=0 throughout, drop_cnt=1, occupancy stays 4, and rcv_ack is still issued.
- Bad CRC (crc_value=0): without the macro, commit with rd_crc_ok=0 and crc_err_cnt=1. With ETH_RX_CRC_DROP_EN: occupancy=0, the next frame goes to slot 0, and crc_err_cnt=1.
- Wrap plus simultaneous events: with occupancy=3, wr_ptr=3 and rd_ptr=0, commit a frame on the same edge as rd_pop. Occupancy stays 3, wr_ptr=0 and rd_ptr=1.
- Pop when empty: occupancy stays 0 and the pointers are unchanged.
- Assert rst mid-frame after 20 writes: all outputs return to 0 asynchronously. After release, the next frame goes to slot 0.
